// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with an IF/ID output register.
// Reads one word per cycle from a combinational instruction memory.
// A word whose top three bits are 111 is a long instruction: the word
// after it is its immediate. The word 1 is HALT, which stops fetching
// until a redirect arrives.
//
// state  | meaning
// -------+---------------------------------------------------------------
// FIRST  | fetching the first (or only) word of an instruction
// SECOND | first word of a long instruction held, fetching its immediate
// HALTED | HALT has been issued; PC frozen until a redirect
module fetch_unit #(
  parameter int          N        = 16,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic [N-1:0] im_addr,
  input  logic [N-1:0] im_data,
  output logic [N-1:0] instr,
  output logic [N-1:0] imm,
  output logic [N-1:0] pc_out,
  output logic         valid
);

  typedef enum logic [1:0] {
    FIRST  = 2'd0,
    SECOND = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] pc;
  logic [N-1:0] pc_inc;
  logic [N-1:0] hold_instr;
  logic [N-1:0] hold_pc;
  logic         is_long;
  logic         is_halt;

  // The memory address is the PC itself; the increment wraps modulo 2^N.
  assign im_addr = pc;
  assign pc_inc  = pc + N'(1);

  // Decode only the bits needed to pick the next state.
  assign is_long = (im_data[N-1 -: 3] == 3'b111);
  assign is_halt = (im_data == N'(1));

  // Fetch FSM with registered IF/ID outputs. Redirect beats stall; stall
  // freezes everything; otherwise the current state decides the update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FIRST;
      pc         <= RESET_PC;
      hold_instr <= '0;
      hold_pc    <= '0;
      instr      <= '0;
      imm        <= '0;
      pc_out     <= '0;
      valid      <= 1'b0;
    end else if (redirect) begin
      // Any held first word is dropped simply by leaving SECOND.
      state <= FIRST;
      pc    <= redirect_pc;
      valid <= 1'b0;
    end else if (!stall) begin
      case (state)
        FIRST: begin
          pc <= pc_inc;
          if (is_long) begin
            hold_instr <= im_data;
            hold_pc    <= pc;
            valid      <= 1'b0;
            state      <= SECOND;
          end else begin
            instr  <= im_data;
            imm    <= '0;
            pc_out <= pc;
            valid  <= 1'b1;
            state  <= is_halt ? HALTED : FIRST;
          end
        end
        SECOND: begin
          instr  <= hold_instr;
          imm    <= im_data;
          pc_out <= hold_pc;
          valid  <= 1'b1;
          pc     <= pc_inc;
          state  <= FIRST;
        end
        HALTED: begin
          valid <= 1'b0;
        end
        default: begin
          state <= FIRST;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven check of fetch_unit against a word memory
// model, with an expected-output scoreboard queue and hand-written
// sequences for wrap-around and asynchronous reset.
module tb_fetch_unit;

  localparam int N = 16;

  logic         clk;
  logic         rst;
  logic         stall;
  logic         redirect;
  logic [N-1:0] redirect_pc;
  logic [N-1:0] im_addr;
  logic [N-1:0] im_data;
  logic [N-1:0] instr;
  logic [N-1:0] imm;
  logic [N-1:0] pc_out;
  logic         valid;

  logic [N-1:0] mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic         valid;
    logic [N-1:0] instr;
    logic [N-1:0] imm;
    logic [N-1:0] pc;
    logic [N-1:0] addr;
  } exp_t;

  typedef struct {
    logic         stall;
    logic         redirect;
    logic [N-1:0] rpc;
    exp_t         e;
  } vec_t;

  exp_t sb[$];

  fetch_unit #(.N(N), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .im_addr(im_addr), .im_data(im_data),
    .instr(instr), .imm(imm), .pc_out(pc_out), .valid(valid)
  );

  assign im_data = mem[im_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".valid"},   N'(valid), N'(e.valid));
    check({tag, ".instr"},   instr,     e.instr);
    check({tag, ".imm"},     imm,       e.imm);
    check({tag, ".pc_out"},  pc_out,    e.pc);
    check({tag, ".im_addr"}, im_addr,   e.addr);
  endtask

  // Drive one cycle of inputs (called mid-cycle), push the expectation,
  // then pop and compare once the edge has produced the new outputs.
  task automatic step(input string tag, input logic s, input logic r,
                      input logic [N-1:0] rpc, input exp_t e);
    exp_t got_e;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      got_e = sb.pop_front();
      check_all(tag, got_e);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [N-1:0] i,
                              input logic [N-1:0] m, input logic [N-1:0] p,
                              input logic [N-1:0] a);
    exp_t e;
    e.valid = v; e.instr = i; e.imm = m; e.pc = p; e.addr = a;
    return e;
  endfunction

  vec_t vecs[20];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[16'h0000] = 16'h1234;
    mem[16'h0001] = 16'h2000;
    mem[16'h0002] = 16'h0001;
    mem[16'h0004] = 16'hE005;
    mem[16'h0005] = 16'hBEEF;
    mem[16'h0006] = 16'h5555;
    mem[16'h0007] = 16'hE111;
    mem[16'h0008] = 16'h2222;
    mem[16'h0040] = 16'h4040;
    mem[16'h0041] = 16'hE7AA;
    mem[16'h0042] = 16'h1357;
    mem[16'h0043] = 16'h0001;
    mem[16'hFFFF] = 16'hE001;

    //                 stall redir rpc        valid instr     imm       pc_out    im_addr
    vecs[0]  = '{1'b0, 1'b0, 16'h0000, mk(1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h0001)};
    vecs[1]  = '{1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h0001)};
    vecs[2]  = '{1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h0001)};
    vecs[3]  = '{1'b1, 1'b0, 16'h0000, mk(1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h0001)};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, mk(1'b1, 16'h2000, 16'h0000, 16'h0001, 16'h0002)};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, mk(1'b1, 16'h0001, 16'h0000, 16'h0002, 16'h0003)};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, mk(1'b0, 16'h0001, 16'h0000, 16'h0002, 16'h0003)};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, mk(1'b0, 16'h0001, 16'h0000, 16'h0002, 16'h0003)};
    vecs[8]  = '{1'b0, 1'b1, 16'h0004, mk(1'b0, 16'h0001, 16'h0000, 16'h0002, 16'h0004)};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, mk(1'b0, 16'h0001, 16'h0000, 16'h0002, 16'h0005)};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, mk(1'b1, 16'hE005, 16'hBEEF, 16'h0004, 16'h0006)};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, mk(1'b1, 16'h5555, 16'h0000, 16'h0006, 16'h0007)};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, mk(1'b0, 16'h5555, 16'h0000, 16'h0006, 16'h0008)};
    vecs[13] = '{1'b1, 1'b1, 16'h0040, mk(1'b0, 16'h5555, 16'h0000, 16'h0006, 16'h0040)};
    vecs[14] = '{1'b0, 1'b0, 16'h0000, mk(1'b1, 16'h4040, 16'h0000, 16'h0040, 16'h0041)};
    vecs[15] = '{1'b0, 1'b0, 16'h0000, mk(1'b0, 16'h4040, 16'h0000, 16'h0040, 16'h0042)};
    vecs[16] = '{1'b1, 1'b0, 16'h0000, mk(1'b0, 16'h4040, 16'h0000, 16'h0040, 16'h0042)};
    vecs[17] = '{1'b0, 1'b0, 16'h0000, mk(1'b1, 16'hE7AA, 16'h1357, 16'h0041, 16'h0043)};
    vecs[18] = '{1'b0, 1'b0, 16'h0000, mk(1'b1, 16'h0001, 16'h0000, 16'h0043, 16'h0044)};
    vecs[19] = '{1'b0, 1'b0, 16'h0000, mk(1'b0, 16'h0001, 16'h0000, 16'h0043, 16'h0044)};

    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    #3;
    check_all("reset", mk(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    @(posedge clk);
    #1;
    check_all("reset_hold", mk(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    rst = 1'b1;

    for (int i = 0; i < 20; i++)
      step($sformatf("vec%0d", i), vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].e);

    // Wrap: long instruction at FFFF takes its immediate from address 0.
    mem[16'h0000] = 16'h0077;
    mem[16'h0001] = 16'h1111;
    step("wrap_redir", 1'b0, 1'b1, 16'hFFFF, mk(1'b0, 16'h0001, 16'h0000, 16'h0043, 16'hFFFF));
    step("wrap_first", 1'b0, 1'b0, 16'h0000, mk(1'b0, 16'h0001, 16'h0000, 16'h0043, 16'h0000));
    step("wrap_second", 1'b0, 1'b0, 16'h0000, mk(1'b1, 16'hE001, 16'h0077, 16'hFFFF, 16'h0001));

    // Asynchronous reset while in SECOND abandons the long instruction.
    step("ar_redir", 1'b0, 1'b1, 16'h0004, mk(1'b0, 16'hE001, 16'h0077, 16'hFFFF, 16'h0004));
    step("ar_first", 1'b0, 1'b0, 16'h0000, mk(1'b0, 16'hE001, 16'h0077, 16'hFFFF, 16'h0005));
    #2;
    rst = 1'b0;
    #1;
    check_all("ar_async", mk(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("ar_held", mk(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    rst = 1'b1;
    step("ar_resume0", 1'b0, 1'b0, 16'h0000, mk(1'b1, 16'h0077, 16'h0000, 16'h0000, 16'h0001));
    step("ar_resume1", 1'b0, 1'b0, 16'h0000, mk(1'b1, 16'h1111, 16'h0000, 16'h0001, 16'h0002));

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
